// File: rtl/ext_bus_pkg.sv
// rtl/ext_bus_pkg.sv - shared encodings and lane helpers for the external bus slave
package ext_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_RELEASE
  } state_t;

  // Size 2'b11 falls through to the word case everywhere.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_read(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane);
    case (size)
      SZ_BYTE: return {24'b0, word[{lane, 3'b000} +: 8]};
      SZ_HALF: return {16'b0, (lane[1] ? word[31:16] : word[15:0])};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/ext_bus_slave_if.sv
// rtl/ext_bus_slave_if.sv - request/response signals between bus master and slave
interface ext_bus_slave_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int EXT_ADDR_WIDTH = 16
);
  logic                      i_bus_en;
  logic                      i_bus_we;
  logic [1:0]                i_bus_size;
  logic [EXT_ADDR_WIDTH-1:0] i_bus_addr;
  logic [DATA_WIDTH-1:0]     b_bus_data_recv;
  logic [DATA_WIDTH-1:0]     b_bus_data_drv;
  logic                      o_bus_rdy;
  logic                      bus_data_o_en;

  modport master (
    output i_bus_en, i_bus_we, i_bus_size, i_bus_addr, b_bus_data_recv,
    input  b_bus_data_drv, o_bus_rdy, bus_data_o_en
  );

  modport slave (
    input  i_bus_en, i_bus_we, i_bus_size, i_bus_addr, b_bus_data_recv,
    output b_bus_data_drv, o_bus_rdy, bus_data_o_en
  );
endinterface

// File: rtl/ext_bus_slave_mem.sv
// rtl/ext_bus_slave_mem.sv - word memory with byte-enable write and registered read
module ext_bus_slave_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ext_bus_slave.sv
// rtl/ext_bus_slave.sv - external bus responder with wait states and lane steering
module ext_bus_slave
  import ext_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int EXT_ADDR_WIDTH = 16,
  parameter int DEPTH_WORDS    = 1024,
  parameter int WAIT_STATES    = 1
) (
  input  logic            clk,
  input  logic            reset,
  ext_bus_slave_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t                    state;
  logic [WCNT_W-1:0]         cnt;
  logic                      lat_we;
  logic [1:0]                lat_size;
  logic [EXT_ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic                      rdy_q;
  logic                      oen_q;
  logic                      lat_in_range;
  logic [IDX_W-1:0]          rd_idx;
  logic [31:0]               wr_data;
  logic [31:0]               mem_q;

  assign lat_in_range = 32'(lat_addr[EXT_ADDR_WIDTH-1:2]) < DEPTH_WORDS;

  // In IDLE the read index comes straight off the bus so zero-wait reads are ready at ACK.
  assign rd_idx = (state == ST_IDLE) ? bus.i_bus_addr[IDX_W+1:2] : lat_addr[IDX_W+1:2];

  always_comb begin
    case (lat_size)
      SZ_BYTE: wr_data = {4{lat_wdata[7:0]}};
      SZ_HALF: wr_data = {2{lat_wdata[15:0]}};
      default: wr_data = lat_wdata;
    endcase
  end

  ext_bus_slave_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we      ((state == ST_ACK) && lat_we && lat_in_range),
    .be      (lane_mask(lat_size, lat_addr[1:0])),
    .wr_idx  (lat_addr[IDX_W+1:2]),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (mem_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_size  <= SZ_BYTE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdy_q     <= 1'b0;
      oen_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_bus_en) begin
            lat_we    <= bus.i_bus_we;
            lat_size  <= bus.i_bus_size;
            lat_addr  <= bus.i_bus_addr;
            lat_wdata <= bus.b_bus_data_recv;
            if (WAIT_STATES > 0) begin
              cnt   <= WCNT_W'(WAIT_STATES - 1);
              state <= ST_WAIT;
            end else begin
              rdy_q <= 1'b1;
              oen_q <= ~bus.i_bus_we;
              state <= ST_ACK;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rdy_q <= 1'b1;
            oen_q <= ~lat_we;
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACK: begin
          rdy_q <= 1'b0;
          oen_q <= 1'b0;
          state <= ST_RELEASE;
        end
        default: begin
          if (!bus.i_bus_en) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_bus_rdy      = rdy_q;
  assign bus.bus_data_o_en  = oen_q;
  assign bus.b_bus_data_drv = (oen_q && lat_in_range) ? lane_read(mem_q, lat_size, lat_addr[1:0]) : '0;

endmodule
